// File: rtl/shift_pkg.sv
// Shared types for the universal shift register.
// Mode encoding used by the register and the bench.
package shift_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_LOAD = 2'b01;
  localparam mode_t MODE_SHR  = 2'b10;
  localparam mode_t MODE_SHL  = 2'b11;

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a registered clock-enable pulse.
// One tick every DIV enabled clk cycles; frozen while en=0.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Phase counter wraps at DIV-1; tick follows the wrap by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (en) begin
      tick  <= (count == LAST);
      count <= (count == LAST) ? '0 : count + 1'b1;
    end else begin
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register: hold, load, shift right/left.
// Updates on prescaler ticks; flags every WIDTH-shift frame.
module shift_reg_univ
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             tick,
  output logic             frame_done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] shl_val;
  logic             upd;
  mode_t            m;

  tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  assign m   = mode_t'(mode);
  assign upd = en & tick;

  // Candidate shifted values for both directions.
  always_comb begin
    shr_val = {sin, q[WIDTH-1:1]};
    shl_val = {q[WIDTH-2:0], sin};
  end

  // Register, shift counter and frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      q          <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (upd) begin
        unique case (m)
          MODE_LOAD: begin
            q       <= din;
            bit_cnt <= '0;
          end
          MODE_SHR, MODE_SHL: begin
            q <= (m == MODE_SHR) ? shr_val : shl_val;
            if (bit_cnt == LAST) begin
              bit_cnt    <= '0;
              frame_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Serial out taps the bit that leaves in the current direction.
  assign sout = (m == MODE_SHR) ? q[0] : q[WIDTH-1];

endmodule
